// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared frame-buffer definitions. The pixel writer and the VGA scan-out both
// import this package, so the two sides always agree on the memory layout:
// 640x480 pixels, one 8-byte slot per pixel, frame starting at a byte base.
//
// Contents:
//   H_RES_C, V_RES_C   frame geometry (also the row stride in pixels)
//   PIXEL_STRIDE       bytes per pixel slot
//   FRAME_BYTES        bytes spanned by one frame
//   FRAME_PIXELS       pixels per frame
//   fb_wr_t            one pending Avalon write {addr, data}
//   fb_state_t         writer state {RUN, DRAIN, FILL}
//   fb_pixel_addr()    byte address of a linear pixel index
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int          H_RES_C      = 640;
    localparam int          V_RES_C      = 480;
    localparam int          PIXEL_STRIDE = 8;
    localparam logic [25:0] FRAME_BYTES  = 26'h258000;
    localparam int          FRAME_PIXELS = 307200;

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        FILL
    } fb_state_t;

    // A 19-bit index shifted by the 8-byte stride gives a 22-bit offset. The
    // add wraps modulo 2^26; there is deliberately no wrap at the frame end.
    function automatic logic [25:0] fb_pixel_addr(input logic [25:0] base,
                                                  input logic [18:0] index);
        return base + {4'b0000, index, 3'b000};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous FIFO of fb_wr_t entries with a registered head read.
// The head register always holds the entry that will be at the front after
// the current edge, so a consumer may pop and use 'head' in the same cycle.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (flushes pointers and count)
//   push       write push_data (ignored when full)
//   push_data  entry to enqueue
//   pop        remove the head entry (ignored when empty)
//   head       current front entry, valid while !empty
//   full       DEPTH entries stored
//   empty      no entries stored
// -----------------------------------------------------------------------------
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [$bits(fb_wr_t)-1:0]   push_data,
    input  logic                        pop,
    output logic [$bits(fb_wr_t)-1:0]   head,
    output logic                        full,
    output logic                        empty
);

    localparam int W  = $bits(fb_wr_t);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered read of the next head slot. When that slot is the one being
    // written this very edge (FIFO empty, or one entry popped while pushing),
    // the RAM still holds stale data, so the incoming word is forwarded.
    always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head <= push_data;
        end else begin
            head <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// -----------------------------------------------------------------------------
// fb_pixel_writer
// Frame-buffer write engine. Pixels (x, y, color) from the renderer are range
// checked, converted to a frame-buffer byte address, queued, and issued as
// 32-bit Avalon-MM writes in accept order through a single output register.
// Optional clear engine (build macro FB_PIXEL_WRITER_CLEAR_EN) fills the whole
// frame with one color after draining pending pixel writes.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   base                frame base byte address (per pixel / latched at clear)
//   in_valid/in_ready   pixel handshake
//   in_x, in_y          pixel column / row
//   in_color            pixel word {8'h0, B, G, R}
//   clear_start         one-cycle fill request
//   clear_color         fill word, latched with clear_start
//   clear_busy          fill in progress (drain or fill)
//   master_*            Avalon-MM write master
//   drop_count          saturating count of out-of-range pixels
//   idle                nothing queued, in flight or filling
// -----------------------------------------------------------------------------
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] base,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [8:0]  in_y,
    input  logic [31:0] in_color,
    input  logic        clear_start,
    input  logic [31:0] clear_color,
    output logic        clear_busy,
    output logic [25:0] master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic [15:0] drop_count,
    output logic        idle
);

    localparam logic [9:0]  H_LIM      = 10'(H_RES);
    localparam logic [8:0]  V_LIM      = 9'(V_RES);
    localparam logic [18:0] LAST_PIXEL = 19'(FRAME_PIXELS - 1);

    fb_state_t   state_reg;
    logic        ready_en_reg;
    logic [15:0] drop_count_reg;
    fb_wr_t      out_reg;
    logic        out_valid_reg;

    logic        accept;
    logic        in_range;
    logic        complete;
    logic        out_free;
    logic        pop;
    logic        fill_load;
    fb_wr_t      fill_word;
    logic [18:0] pix_index;
    fb_wr_t      pix_word;
    logic [$bits(fb_wr_t)-1:0] fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    // Address always uses the fixed 640-pixel row stride of the frame layout,
    // independent of the H_RES limit used for range checking.
    assign pix_index     = 19'(in_y) * 19'(H_RES_C) + 19'(in_x);
    assign pix_word.addr = fb_pixel_addr(base, pix_index);
    assign pix_word.data = in_color;

    assign accept   = in_valid && in_ready;
    assign in_range = (in_x < H_LIM) && (in_y < V_LIM);
    assign complete = out_valid_reg && !master_waitrequest;
    assign out_free = !out_valid_reg || complete;
    assign pop      = out_free && !fifo_empty;

    fb_wr_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && in_range),
        .push_data (pix_word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Holds in_ready low for the reset cycle and releases it one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count_reg <= '0;
        end else if (accept && !in_range && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    // Output register: reloads in the same cycle its write completes, so
    // back-to-back writes go out at one per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (pop) begin
            out_reg       <= fifo_head;
            out_valid_reg <= 1'b1;
        end else if (fill_load) begin
            out_reg       <= fill_word;
            out_valid_reg <= 1'b1;
        end else if (complete) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    fb_state_t   state_next;
    logic [31:0] clear_color_reg;
    logic [25:0] fill_base_reg;
    logic [18:0] fill_cnt_reg;
    logic [18:0] fill_index;
    logic        fill_done;

    // During FILL the output register always holds write number fill_cnt_reg
    // (the count of completed fill writes), so the next index to load is one
    // past it, or fill_cnt_reg itself when the register is still empty.
    assign fill_done  = (state_reg == FILL) && complete && (fill_cnt_reg == LAST_PIXEL);
    assign fill_index = out_valid_reg ? fill_cnt_reg + 19'd1 : fill_cnt_reg;
    assign fill_load  = (state_reg == FILL) && out_free &&
                        !(out_valid_reg && (fill_cnt_reg == LAST_PIXEL));
    assign fill_word.addr = fb_pixel_addr(fill_base_reg, fill_index);
    assign fill_word.data = clear_color_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (clear_start) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !out_valid_reg) state_next = FILL;
            FILL:    if (fill_done) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_color_reg <= '0;
            fill_base_reg   <= '0;
        end else if ((state_reg == RUN) && clear_start) begin
            clear_color_reg <= clear_color;
            fill_base_reg   <= base;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt_reg <= '0;
        end else if ((state_reg == FILL) && complete) begin
            fill_cnt_reg <= fill_done ? 19'd0 : fill_cnt_reg + 19'd1;
        end
    end

    assign clear_busy = (state_reg != RUN);
`else
    logic unused_clear;

    assign state_reg    = RUN;
    assign fill_load    = 1'b0;
    assign fill_word    = '0;
    assign clear_busy   = 1'b0;
    assign unused_clear = ^{clear_start, clear_color, LAST_PIXEL};
`endif

    always_comb begin
        in_ready = ready_en_reg && (state_reg == RUN) && !fifo_full;
        idle     = (state_reg == RUN) && fifo_empty && !out_valid_reg;
    end

    assign master_write     = out_valid_reg;
    assign master_address   = out_reg.addr;
    assign master_writedata = out_reg.data;
    assign drop_count       = drop_count_reg;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_pixel_writer
// Directed bench for fb_pixel_writer: reset values, single pixel latency,
// waitrequest stalls, FIFO backpressure, range drops, clear behaviour and
// asynchronous reset in the middle of a burst.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_pixel_writer;

    logic        clk;
    logic        reset;
    logic [25:0] base;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic [31:0] in_color;
    logic        clear_start;
    logic [31:0] clear_color;
    logic        clear_busy;
    logic [25:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic [15:0] drop_count;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0] wa_q[$];
    logic [31:0] wd_q[$];

    fb_pixel_writer #(
        .FIFO_DEPTH (16),
        .H_RES      (640),
        .V_RES      (480)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .base               (base),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_x               (in_x),
        .in_y               (in_y),
        .in_color           (in_color),
        .clear_start        (clear_start),
        .clear_color        (clear_color),
        .clear_busy         (clear_busy),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .drop_count         (drop_count),
        .idle               (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completed Avalon writes, in order.
    always @(posedge clk) begin
        if (reset && master_write && !master_waitrequest) begin
            wa_q.push_back(master_address);
            wd_q.push_back(master_writedata);
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int start;
        int acc;
        int next_px;
        int guard;
        int bad;
        logic [25:0] hold_addr;
        logic [31:0] hold_data;

        reset              = 1'b0;
        base               = 26'h100000;
        in_valid           = 1'b0;
        in_x               = '0;
        in_y               = '0;
        in_color           = '0;
        clear_start        = 1'b0;
        clear_color        = '0;
        master_waitrequest = 1'b0;

        // ---- reset values ----
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_write", master_write, 0);
        chk("rst_address", master_address, 0);
        chk("rst_writedata", master_writedata, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        $display("txn reset: in_ready=%0d idle=%0d", in_ready, idle);

        // ---- single pixel: x=3 y=2 -> 0x100000 + 1283*8 = 0x102818 ----
        start    = wa_q.size();
        in_valid = 1'b1;
        in_x     = 10'd3;
        in_y     = 9'd2;
        in_color = 32'h00FF00FF;
        tick();
        in_valid = 1'b0;
        chk("single_no_bypass", master_write, 0);
        tick();
        chk("single_write", master_write, 1);
        chk("single_addr", master_address, 26'h102818);
        chk("single_data", master_writedata, 32'h00FF00FF);
        tick();
        chk("single_write_done", master_write, 0);
        chk("single_idle", idle, 1);
        chk("single_count", wa_q.size() - start, 1);
        $display("txn single: addr=%0h data=%0h", wa_q[start], wd_q[start]);

        // ---- same pixel, waitrequest high 5 cycles ----
        start              = wa_q.size();
        master_waitrequest = 1'b1;
        in_valid           = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!master_write || master_address !== 26'h102818 ||
                master_writedata !== 32'h00FF00FF) bad++;
            tick();
        end
        master_waitrequest = 1'b0;
        chk("stall_unstable_cycles", bad, 0);
        chk("stall_write_6th", master_write, 1);
        chk("stall_addr_6th", master_address, 26'h102818);
        chk("stall_no_early_write", wa_q.size() - start, 0);
        tick();
        chk("stall_write_done", master_write, 0);
        chk("stall_count", wa_q.size() - start, 1);
        $display("txn stall: writes=%0d", wa_q.size() - start);

        // ---- backpressure: 20 pixels offered with waitrequest high ----
        start              = wa_q.size();
        master_waitrequest = 1'b1;
        acc                = 0;
        next_px            = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_x     = 10'(next_px);
            in_y     = 9'd5;
            in_color = 32'(next_px);
            if (in_ready) begin
                acc++;
                next_px++;
            end
            tick();
        end
        chk("bp_accepted", acc, 17);
        chk("bp_in_ready_low", in_ready, 0);
        master_waitrequest = 1'b0;
        guard = 0;
        while (next_px < 20 && guard < 100) begin
            in_valid = 1'b1;
            in_x     = 10'(next_px);
            in_y     = 9'd5;
            in_color = 32'(next_px);
            if (in_ready) next_px++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", next_px, 20);
        guard = 0;
        while (wa_q.size() < start + 20 && guard < 200) begin
            tick();
            guard++;
        end
        chk("bp_write_count", wa_q.size() - start, 20);
        // Row 5 starts at 5*640*8 = 0x6400 past base.
        for (int i = 0; i < 20; i++) begin
            if (start + i < wa_q.size()) begin
                chk("bp_addr", wa_q[start+i], 26'h106400 + 26'(8*i));
                chk("bp_data", wd_q[start+i], 32'(i));
                $display("txn bp[%0d]: addr=%0h data=%0h", i, wa_q[start+i], wd_q[start+i]);
            end
        end

        // ---- out-of-range pixels ----
        start    = wa_q.size();
        in_valid = 1'b1;
        in_x     = 10'd640;
        in_y     = 9'd0;
        chk("drop1_in_ready", in_ready, 1);
        tick();
        in_x = 10'd0;
        in_y = 9'd480;
        chk("drop2_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("drop_in_ready_after", in_ready, 1);
        chk("drop_count", drop_count, 2);
        repeat (5) tick();
        chk("drop_no_writes", wa_q.size() - start, 0);
        chk("drop_idle", idle, 1);
        $display("txn drop: drop_count=%0d", drop_count);

`ifdef FB_PIXEL_WRITER_CLEAR_EN
        // ---- frame fill ----
        start       = wa_q.size();
        base        = 26'h100000;
        clear_color = 32'h00123456;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("fill_busy_rise", clear_busy, 1);
        chk("fill_in_ready", in_ready, 0);
        bad   = 0;
        guard = 0;
        while (wa_q.size() < start + 307200 && guard < 400000) begin
            if (!clear_busy || in_ready) bad++;
            tick();
            guard++;
        end
        chk("fill_count", wa_q.size() - start, 307200);
        chk("fill_busy_fall", clear_busy, 0);
        chk("fill_busy_throughout", bad, 0);
        if (wa_q.size() >= start + 307200) begin
            chk("fill_first_addr", wa_q[start], 26'h100000);
            chk("fill_first_data", wd_q[start], 32'h00123456);
            chk("fill_last_addr", wa_q[start+307199], 26'h357FF8);
            chk("fill_last_data", wd_q[start+307199], 32'h00123456);
        end
        $display("txn fill: writes=%0d", wa_q.size() - start);
`else
        // ---- clear request ignored when the clear engine is absent ----
        start       = wa_q.size();
        clear_color = 32'h00123456;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("noclr_busy", clear_busy, 0);
        chk("noclr_in_ready", in_ready, 1);
        repeat (3) tick();
        chk("noclr_no_writes", wa_q.size() - start, 0);
        chk("noclr_idle", idle, 1);
        $display("txn clear ignored: clear_busy=%0d", clear_busy);
`endif

        // ---- asynchronous reset mid-burst ----
        master_waitrequest = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_x     = 10'(i);
            in_y     = 9'd1;
            in_color = 32'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("burst_write_pending", master_write, 1);
        chk("burst_not_idle", idle, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_write", master_write, 0);
        chk("async_rst_in_ready", in_ready, 0);
        chk("async_rst_drop", drop_count, 0);
        start              = wa_q.size();
        master_waitrequest = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("after_rst_no_writes", wa_q.size() - start, 0);
        chk("after_rst_idle", idle, 1);
        chk("after_rst_drop", drop_count, 0);
        chk("after_rst_in_ready", in_ready, 1);
        $display("txn reset mid-burst: writes_after=%0d", wa_q.size() - start);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
